inst_queue: RTL and testbench

- Instruction prefetch queue between the fetch stage (ifu) and the decode stage (idu). It replaces the plain ifu_idu pipeline register.
- Buffers fetched instruction/PC pairs in a small circular FIFO.
- Absorbs decode stalls without losing the in-flight fetch.
- Requests a PC hold from pipe_ctrl when nearly full, and empties on flush.

---
 rtl/inst_queue.sv | 118 +++++++++++
 tb/tb_inst_queue.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_queue.sv
// Instruction prefetch queue between fetch (ifu) and decode (idu): a small circular FIFO of {pc, inst}.
// Optional zero-latency empty-queue bypass is enabled by defining INST_QUEUE_BYPASS_EN.

`ifndef InstBus
`define InstBus 31:0
`endif
`ifndef InstAddrBus
`define InstAddrBus 31:0
`endif
`ifndef StallBus
`define StallBus 5:0
`endif
`ifndef Stall_id
`define Stall_id 2
`endif

module inst_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [`InstBus]            inst_i,
    input  logic [`InstAddrBus]        inst_addr_i,
    input  logic                       inst_valid_i,
    input  logic [`StallBus]           stall_i,
    input  logic                       flush_i,
    output logic [`InstBus]            inst_o,
    output logic [`InstAddrBus]        inst_addr_o,
    output logic                       inst_valid_o,
    output logic                       stallreq_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int IW = $bits(inst_i);
    localparam int PW = $bits(inst_addr_i);

    logic [PW+IW-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_empty;
    logic w_full;
    logic w_stall_id;
    logic w_bypass;
    logic w_deq;
    logic w_enq;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CW'(DEPTH));
    assign w_stall_id = stall_i[`Stall_id];

`ifdef INST_QUEUE_BYPASS_EN
    // An empty queue with an unstalled decoder hands the fetch straight through.
    assign w_bypass = w_empty && inst_valid_i && !w_stall_id && !flush_i;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_deq = !w_empty && !w_stall_id && !flush_i;
    assign w_enq = inst_valid_i && !flush_i && (!w_full || w_deq) && !w_bypass;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_deq) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry contents carry no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (w_enq) r_mem[r_wr_ptr] <= {inst_addr_i, inst_i};
    end

    always_comb begin
        inst_o       = NOP_INST;
        inst_addr_o  = '0;
        inst_valid_o = 1'b0;
        if (w_bypass) begin
            inst_o       = inst_i;
            inst_addr_o  = inst_addr_i;
            inst_valid_o = 1'b1;
        end else if (!w_empty) begin
            {inst_addr_o, inst_o} = r_mem[r_rd_ptr];
            inst_valid_o          = 1'b1;
        end
    end

    // One slot of slack covers the fetch already in flight when pipe_ctrl holds the PC.
    assign stallreq_o = (r_count >= CW'(DEPTH - 1));
    assign count_o    = r_count;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(inst_valid_i && !flush_i && w_full && !w_deq))
            else $warning("inst_queue: fetch arrived while full, instruction dropped at %0t", $time);
        end
    end
`endif

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue: reset, streaming, fill/overflow, full enq+deq, flush, bypass latency.
// Expected values follow the queue behaviour; INST_QUEUE_BYPASS_EN selects the bypass expectations.

`ifndef InstBus
`define InstBus 31:0
`endif
`ifndef InstAddrBus
`define InstAddrBus 31:0
`endif
`ifndef StallBus
`define StallBus 5:0
`endif
`ifndef Stall_id
`define Stall_id 2
`endif

module tb_inst_queue;

    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef INST_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic               clk;
    logic               rst_n;
    logic [`InstBus]    inst_i;
    logic [`InstAddrBus] inst_addr_i;
    logic               inst_valid_i;
    logic [`StallBus]   stall_i;
    logic               flush_i;
    logic [`InstBus]    inst_o;
    logic [`InstAddrBus] inst_addr_o;
    logic               inst_valid_o;
    logic               stallreq_o;
    logic [2:0]         count_o;

    int n_tests;
    int n_fail;
    logic [31:0] exp_q[$];

    inst_queue #(.DEPTH(DEPTH), .NOP_INST(NOP)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .inst_i       (inst_i),
        .inst_addr_i  (inst_addr_i),
        .inst_valid_i (inst_valid_i),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o),
        .inst_valid_o (inst_valid_o),
        .stallreq_o   (stallreq_o),
        .count_o      (count_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk_inst(input logic [31:0] a);
        return {a[15:0], 16'h0513};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a);
        inst_valid_i = v;
        inst_addr_i  = a;
        inst_i       = mk_inst(a);
    endtask

    task automatic set_stall(input logic s);
        stall_i            = '0;
        stall_i[`Stall_id] = s;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 32'h0);
        set_stall(1'b0);
        flush_i = 1'b0;
        #3;
        n_tests++;
        if (inst_valid_o !== 1'b0 || inst_o !== NOP || inst_addr_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_out: valid=%b inst=%h addr=%h want 0/%h/0", inst_valid_o, inst_o, inst_addr_o, NOP);
        end
        n_tests++;
        if (count_o !== 3'd0 || stallreq_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_cnt: count=%0d stallreq=%b want 0/0", count_o, stallreq_o);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_streaming();
        logic [31:0] a;
        set_stall(1'b0);
        for (int k = 0; k < 3; k++) begin
            a = 32'h8000_0000 + 32'(k * 4);
            drive(1'b1, a);
            tick();
            n_tests++;
            if (inst_addr_o !== a || inst_o !== mk_inst(a) || inst_valid_o !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_head%0d: addr=%h inst=%h valid=%b want %h/%h/1", k, inst_addr_o, inst_o, inst_valid_o, a, mk_inst(a));
            end
            n_tests++;
            if (count_o !== (BYP ? 3'd0 : 3'd1)) begin
                n_fail++;
                $display("FAIL stream_cnt%0d: count=%0d want %0d", k, count_o, BYP ? 0 : 1);
            end
        end
        drive(1'b0, 32'h0);
        tick();
        n_tests++;
        if (count_o !== 3'd0 || inst_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_empty: count=%0d valid=%b want 0/0", count_o, inst_valid_o);
        end
    endtask

    task automatic test_fill_stall();
        logic [31:0] a;
        set_stall(1'b1);
        for (int k = 0; k < 4; k++) begin
            a = 32'h8000_0040 + 32'(k * 4);
            drive(1'b1, a);
            tick();
            exp_q.push_back(a);
            n_tests++;
            if (count_o !== 3'(k + 1) || stallreq_o !== (k + 1 >= 3)) begin
                n_fail++;
                $display("FAIL fill_cnt%0d: count=%0d stallreq=%b want %0d/%b", k, count_o, stallreq_o, k + 1, (k + 1 >= 3));
            end
            n_tests++;
            if (inst_addr_o !== exp_q[0]) begin
                n_fail++;
                $display("FAIL fill_head%0d: addr=%h want %h", k, inst_addr_o, exp_q[0]);
            end
        end
        // fifth fetch while full and stalled is dropped
        drive(1'b1, 32'h8000_00F0);
        tick();
        n_tests++;
        if (count_o !== 3'd4 || inst_addr_o !== exp_q[0]) begin
            n_fail++;
            $display("FAIL overflow: count=%0d addr=%h want 4/%h", count_o, inst_addr_o, exp_q[0]);
        end
    endtask

    task automatic test_full_enq_deq();
        set_stall(1'b0);
        drive(1'b1, 32'h8000_0100);
        tick();
        void'(exp_q.pop_front());
        exp_q.push_back(32'h8000_0100);
        n_tests++;
        if (count_o !== 3'd4 || stallreq_o !== 1'b1 || inst_addr_o !== exp_q[0]) begin
            n_fail++;
            $display("FAIL full_swap: count=%0d stallreq=%b addr=%h want 4/1/%h", count_o, stallreq_o, inst_addr_o, exp_q[0]);
        end
        drive(1'b0, 32'h0);
        while (exp_q.size() > 0) begin
            n_tests++;
            if (inst_addr_o !== exp_q[0] || inst_o !== mk_inst(exp_q[0]) || inst_valid_o !== 1'b1) begin
                n_fail++;
                $display("FAIL drain: addr=%h inst=%h valid=%b want %h/%h/1", inst_addr_o, inst_o, inst_valid_o, exp_q[0], mk_inst(exp_q[0]));
            end
            tick();
            void'(exp_q.pop_front());
            n_tests++;
            if (count_o !== 3'(exp_q.size())) begin
                n_fail++;
                $display("FAIL drain_cnt: count=%0d want %0d", count_o, exp_q.size());
            end
        end
        n_tests++;
        if (inst_valid_o !== 1'b0 || inst_o !== NOP) begin
            n_fail++;
            $display("FAIL drain_empty: valid=%b inst=%h want 0/%h", inst_valid_o, inst_o, NOP);
        end
    endtask

    task automatic test_flush();
        set_stall(1'b1);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h8000_0010 + 32'(k * 4));
            tick();
        end
        n_tests++;
        if (count_o !== 3'd3 || stallreq_o !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_pre: count=%0d stallreq=%b want 3/1", count_o, stallreq_o);
        end
        flush_i = 1'b1;
        drive(1'b1, 32'h8000_0200);
        tick();
        flush_i = 1'b0;
        drive(1'b0, 32'h0);
        set_stall(1'b0);
        n_tests++;
        if (count_o !== 3'd0 || inst_valid_o !== 1'b0 || inst_o !== NOP || inst_addr_o !== 32'h0) begin
            n_fail++;
            $display("FAIL flush_post: count=%0d valid=%b inst=%h addr=%h want 0/0/%h/0", count_o, inst_valid_o, inst_o, inst_addr_o, NOP);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_tests++;
            if (inst_valid_o !== 1'b0 || inst_addr_o === 32'h8000_0200) begin
                n_fail++;
                $display("FAIL flush_leak%0d: valid=%b addr=%h want 0/not 80000200", k, inst_valid_o, inst_addr_o);
            end
        end
    endtask

    task automatic test_reset_mid();
        set_stall(1'b1);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h8000_0020 + 32'(k * 4));
            tick();
        end
        drive(1'b0, 32'h0);
        n_tests++;
        if (count_o !== 3'd3) begin
            n_fail++;
            $display("FAIL rstmid_pre: count=%0d want 3", count_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (inst_valid_o !== 1'b0 || inst_o !== NOP || count_o !== 3'd0 || stallreq_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_async: valid=%b inst=%h count=%0d stallreq=%b want 0/%h/0/0", inst_valid_o, inst_o, count_o, stallreq_o, NOP);
        end
        @(negedge clk);
        rst_n = 1'b1;
        set_stall(1'b0);
        repeat (2) tick();
        n_tests++;
        if (inst_valid_o !== 1'b0 || inst_o !== NOP || count_o !== 3'd0) begin
            n_fail++;
            $display("FAIL rstmid_hold: valid=%b inst=%h count=%0d want 0/%h/0", inst_valid_o, inst_o, count_o, NOP);
        end
    endtask

    task automatic test_bypass();
        set_stall(1'b0);
        drive(1'b1, 32'h8000_0300);
        #1;
        n_tests++;
        if (inst_valid_o !== BYP || inst_addr_o !== (BYP ? 32'h8000_0300 : 32'h0)) begin
            n_fail++;
            $display("FAIL bypass_same: valid=%b addr=%h want %b/%h", inst_valid_o, inst_addr_o, BYP, BYP ? 32'h8000_0300 : 32'h0);
        end
        tick();
        n_tests++;
        if (inst_addr_o !== 32'h8000_0300 || inst_valid_o !== 1'b1 || count_o !== (BYP ? 3'd0 : 3'd1)) begin
            n_fail++;
            $display("FAIL bypass_next: addr=%h valid=%b count=%0d want 80000300/1/%0d", inst_addr_o, inst_valid_o, count_o, BYP ? 0 : 1);
        end
        drive(1'b0, 32'h0);
        tick();
        n_tests++;
        if (count_o !== 3'd0 || inst_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL bypass_done: count=%0d valid=%b want 0/0", count_o, inst_valid_o);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_streaming();
        test_fill_stall();
        test_full_enq_deq();
        test_flush();
        test_reset_mid();
        test_bypass();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
